shift_arbiter: RTL and testbench



---
 rtl/shift_arbiter_if.sv | 47 ++++
 rtl/shift_arbiter.sv | 103 ++++++++++
 tb/tb_shift_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// Request, shifter-drive and result signals between the shift arbiter and its
// requesters, the external barrel shifter and the result consumer.
interface shift_arbiter_if #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [31:0]      req_x0;
    logic [31:0]      req_x1;
    logic [4:0]       req_sa0;
    logic [4:0]       req_sa1;
    logic             req_arith0;
    logic             req_arith1;
    logic             req_right0;
    logic             req_right1;
    logic [TAG_W-1:0] req_tag0;
    logic [TAG_W-1:0] req_tag1;
    logic [31:0]      sh_x;
    logic [4:0]       sh_sa;
    logic             sh_arith;
    logic             sh_right;
    logic [31:0]      sh_result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_id;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    modport slave (
        input  req_valid, req_x0, req_x1, req_sa0, req_sa1,
               req_arith0, req_arith1, req_right0, req_right1,
               req_tag0, req_tag1, sh_result, out_ready,
        output req_ready, sh_x, sh_sa, sh_arith, sh_right,
               out_valid, out_data, out_id, out_tag, grant_cnt0, grant_cnt1
    );

    modport master (
        output req_valid, req_x0, req_x1, req_sa0, req_sa1,
               req_arith0, req_arith1, req_right0, req_right1,
               req_tag0, req_tag1, sh_result, out_ready,
        input  req_ready, sh_x, sh_sa, sh_arith, sh_right,
               out_valid, out_data, out_id, out_tag, grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one external 32-bit barrel shifter between two
// requesters; captures the shifter result in a single-entry handshake register.
module shift_arbiter #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    shift_arbiter_if.slave bus
);

    logic             prio_q, prio_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_id_q, out_id_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             can_issue;
    logic             any_req;
    logic             win;
    logic [1:0]       ready;
    logic             xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        can_issue = !out_valid_q || bus.out_ready;
        any_req   = |bus.req_valid;
        // With a single requester it wins outright; prio only breaks ties.
        win       = (&bus.req_valid) ? prio_q : bus.req_valid[1];

        ready = 2'b00;
        if (can_issue && any_req && !Reset) begin
            ready = win ? 2'b10 : 2'b01;
        end
        xfer = |(bus.req_valid & ready);

        bus.sh_x     = 32'd0;
        bus.sh_sa    = 5'd0;
        bus.sh_arith = 1'b0;
        bus.sh_right = 1'b0;
        if (any_req) begin
            bus.sh_x     = win ? bus.req_x1     : bus.req_x0;
            bus.sh_sa    = win ? bus.req_sa1    : bus.req_sa0;
            bus.sh_arith = win ? bus.req_arith1 : bus.req_arith0;
            bus.sh_right = win ? bus.req_right1 : bus.req_right0;
        end
    end

    always_comb begin
        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_tag_d   = out_tag_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.sh_result;
            out_id_d    = win;
            out_tag_d   = win ? bus.req_tag1 : bus.req_tag0;
            prio_d      = ~win;
            if (win) cnt1_d = sat_inc(cnt1_q);
            else     cnt0_d = sat_inc(cnt0_q);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_id_q    <= 1'b0;
            out_tag_q   <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_tag_q   <= out_tag_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed steps then random traffic against a
// transaction-level model; a CNT_W=4 instance covers counter saturation.
module tb_shift_arbiter;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    shift_arbiter_if #(.TAG_W(4), .CNT_W(16)) bus ();
    shift_arbiter_if #(.TAG_W(4), .CNT_W(4))  bus4 ();

    shift_arbiter #(.TAG_W(4), .CNT_W(16)) dut  (.Clk(Clk), .Reset(Reset), .bus(bus));
    shift_arbiter #(.TAG_W(4), .CNT_W(4))  dut4 (.Clk(Clk), .Reset(Reset), .bus(bus4));

    // Behavioural barrel shifter standing in for the external unit.
    function automatic logic [31:0] shf(input logic [31:0] xv, input logic [4:0] s,
                                        input logic a, input logic r);
        if (!r) return xv << s;
        if (a)  return 32'($signed(xv) >>> s);
        return xv >> s;
    endfunction

    logic [1:0]  rv;
    logic [31:0] x  [2];
    logic [4:0]  sa [2];
    logic        ar [2];
    logic        rt [2];
    logic [3:0]  tg [2];
    logic        ordy;
    logic        rv4;

    assign bus.req_valid  = rv;
    assign bus.req_x0     = x[0];
    assign bus.req_x1     = x[1];
    assign bus.req_sa0    = sa[0];
    assign bus.req_sa1    = sa[1];
    assign bus.req_arith0 = ar[0];
    assign bus.req_arith1 = ar[1];
    assign bus.req_right0 = rt[0];
    assign bus.req_right1 = rt[1];
    assign bus.req_tag0   = tg[0];
    assign bus.req_tag1   = tg[1];
    assign bus.out_ready  = ordy;
    assign bus.sh_result  = shf(bus.sh_x, bus.sh_sa, bus.sh_arith, bus.sh_right);

    assign bus4.req_valid  = {1'b0, rv4};
    assign bus4.req_x0     = 32'h1;
    assign bus4.req_x1     = 32'h0;
    assign bus4.req_sa0    = 5'd1;
    assign bus4.req_sa1    = 5'd0;
    assign bus4.req_arith0 = 1'b0;
    assign bus4.req_arith1 = 1'b0;
    assign bus4.req_right0 = 1'b0;
    assign bus4.req_right1 = 1'b0;
    assign bus4.req_tag0   = 4'h0;
    assign bus4.req_tag1   = 4'h0;
    assign bus4.out_ready  = 1'b1;
    assign bus4.sh_result  = shf(bus4.sh_x, bus4.sh_sa, bus4.sh_arith, bus4.sh_right);

    // Reference model state: what the result register and arbiter should hold.
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_id;
    logic [3:0]  m_tag;
    logic        m_prio;
    logic [15:0] m_cnt [2];
    logic [1:0]  pend;
    logic [1:0]  obs_ready;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setp(input int p, input logic [31:0] xv, input logic [4:0] s,
                        input logic a, input logic r, input logic [3:0] t);
        x[p]  = xv;
        sa[p] = s;
        ar[p] = a;
        rt[p] = r;
        tg[p] = t;
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = 32'd0;
        m_id     = 1'b0;
        m_tag    = 4'd0;
        m_prio   = 1'b0;
        m_cnt[0] = 16'd0;
        m_cnt[1] = 16'd0;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model at
    // the edge, then check the registered outputs just after it.
    task automatic cycle();
        logic       hasw;
        int         w;
        logic [1:0] er;
        @(negedge Clk);
        hasw = (rv != 2'b00);
        if (rv == 2'b11) w = int'(m_prio);
        else             w = rv[1] ? 1 : 0;
        er = 2'b00;
        if (hasw && !Reset && (!m_valid || ordy)) er[w] = 1'b1;
        obs_ready = bus.req_ready;
        chk("req_ready", bus.req_ready, er);
        chk("sh_x", bus.sh_x, hasw ? x[w] : 32'd0);
        chk("sh_ctl", {bus.sh_sa, bus.sh_arith, bus.sh_right},
            hasw ? {sa[w], ar[w], rt[w]} : 7'd0);
        @(posedge Clk);
        #1;
        if (Reset) begin
            model_reset();
        end else if (er != 2'b00) begin
            m_valid = 1'b1;
            m_data  = shf(x[w], sa[w], ar[w], rt[w]);
            m_id    = (w == 1);
            m_tag   = tg[w];
            m_prio  = (w == 0);
            if (m_cnt[w] != 16'hFFFF) m_cnt[w] = m_cnt[w] + 16'd1;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        pend = rv & ~er;
        chk("out_valid", bus.out_valid, m_valid);
        chk("out_data", bus.out_data, m_data);
        chk("out_id", bus.out_id, m_id);
        chk("out_tag", bus.out_tag, m_tag);
        chk("grant_cnt0", bus.grant_cnt0, m_cnt[0]);
        chk("grant_cnt1", bus.grant_cnt1, m_cnt[1]);
    endtask

    initial begin
        model_reset();
        pend = 2'b00;
        rv4  = 1'b0;
        ordy = 1'b1;
        setp(0, 32'd0, 5'd0, 1'b0, 1'b0, 4'd0);
        setp(1, 32'd0, 5'd0, 1'b0, 1'b0, 4'd0);

        // Reset with both requesting: nothing may be accepted.
        Reset = 1'b1;
        rv    = 2'b11;
        cycle();
        cycle();
        chk("rst_ready", obs_ready, 2'b00);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_cnt", {bus.grant_cnt0, bus.grant_cnt1}, 32'd0);

        Reset = 1'b0;
        rv = 2'b01;
        setp(0, 32'h8000_0000, 5'd4, 1'b1, 1'b1, 4'd3);
        cycle();
        chk("p0_valid", bus.out_valid, 1'b1);
        chk("p0_data", bus.out_data, 32'hF800_0000);
        chk("p0_id", bus.out_id, 1'b0);
        chk("p0_tag", bus.out_tag, 4'd3);
        chk("p0_cnt", bus.grant_cnt0, 16'd1);

        rv = 2'b10;
        setp(1, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 4'd5);
        cycle();
        chk("p1_sa31", bus.out_data, 32'h8000_0000);
        chk("p1_id", bus.out_id, 1'b1);
        setp(1, 32'h0000_0001, 5'd0, 1'b0, 1'b0, 4'd5);
        cycle();
        chk("p1_sa0", bus.out_data, 32'h0000_0001);

        Reset = 1'b1;
        rv = 2'b00;
        cycle();
        Reset = 1'b0;

        // Both requesting back to back: strict alternation from port 0.
        rv = 2'b11;
        setp(0, 32'h0000_00F0, 5'd4, 1'b0, 1'b1, 4'd1);
        setp(1, 32'h0000_000F, 5'd8, 1'b0, 1'b0, 4'd2);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_id", bus.out_id, (k % 2 == 1));
            chk("rr_valid", bus.out_valid, 1'b1);
        end
        chk("rr_cnt0", bus.grant_cnt0, 16'd2);
        chk("rr_cnt1", bus.grant_cnt1, 16'd2);

        // Stall with result held, then release.
        ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_ready", obs_ready, 2'b00);
            chk("stall_data", bus.out_data, 32'h0000_0F00);
            chk("stall_id", bus.out_id, 1'b1);
        end
        ordy = 1'b1;
        cycle();
        chk("unstall_ready", obs_ready, 2'b01);
        chk("unstall_data", bus.out_data, 32'h0000_000F);

        // Reset while holding a result and both requesting.
        ordy  = 1'b0;
        Reset = 1'b1;
        cycle();
        chk("midrst_ready", obs_ready, 2'b00);
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_cnt", {bus.grant_cnt0, bus.grant_cnt1}, 32'd0);
        Reset = 1'b0;
        ordy  = 1'b1;
        cycle();
        chk("postrst_ready", obs_ready, 2'b01);
        chk("postrst_id", bus.out_id, 1'b0);

        // Random traffic; a requester keeps its operation stable until accepted.
        for (int n = 0; n < 400; n++) begin
            Reset = ($urandom_range(0, 63) == 0);
            ordy  = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    rv[p] = ($urandom_range(0, 3) != 0);
                    setp(p, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                end
            end
            cycle();
        end

        // Saturation on the narrow-counter instance.
        Reset = 1'b1;
        rv    = 2'b00;
        cycle();
        Reset = 1'b0;
        rv4   = 1'b1;
        repeat (14) cycle();
        chk("sat_14", bus4.grant_cnt0, 4'hE);
        cycle();
        chk("sat_15", bus4.grant_cnt0, 4'hF);
        repeat (2) cycle();
        chk("sat_17", bus4.grant_cnt0, 4'hF);
        chk("sat_cnt1", bus4.grant_cnt1, 4'h0);
        chk("sat_data", bus4.out_data, 32'h2);
        rv4 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
